// File: rtl/data_memory_ctl.sv
// rtl/data_memory_ctl.sv - byte-enable data memory with registered read, range check and post-reset clear
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_be   write request with per-byte enables
//   rd_en/rd_addr      read request
//   rd_data/rd_valid   registered read data and its one-cycle strobe
//   ready              high once the clear sequence has zeroed every word
//   addr_err           one-cycle strobe for an out-of-range request in the previous cycle
module data_memory_ctl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 20,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  ready,
    output logic                  addr_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    clr_ptr, clr_ptr_next;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   rd_data_next;
    logic                rd_valid_next;
    logic                addr_err_next;

    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                wr_in_range, rd_in_range;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DATA_W-1:0]   merged;

    // Full-width comparison: high address bits must not alias into the array.
    assign wr_in_range = (wr_addr < DEPTH_A);
    assign rd_in_range = (rd_addr < DEPTH_A);
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];

    assign ready = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            clr_ptr  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_next;
            clr_ptr  <= clr_ptr_next;
            rd_data  <= rd_data_next;
            rd_valid <= rd_valid_next;
            addr_err <= addr_err_next;
        end
    end

    // The array has no reset; the clear sequence is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_next    = state;
        clr_ptr_next  = clr_ptr;
        rd_data_next  = rd_data;
        rd_valid_next = 1'b0;
        addr_err_next = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = wr_idx;
        mem_wdata     = '0;

        // Post-write word for the addressed location; also used for write-first collisions.
        merged = mem[wr_idx];
        for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
                merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end

        case (state)
            INIT: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_ptr;
                mem_wdata    = '0;
                clr_ptr_next = clr_ptr + 1'b1;
                if (clr_ptr == LAST_IDX) begin
                    state_next   = RUN;
                    clr_ptr_next = '0;
                end
            end
            RUN: begin
                if (wr_en && wr_in_range && (wr_be != '0)) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_idx;
                    mem_wdata = merged;
                end
                if (rd_en) begin
                    rd_valid_next = 1'b1;
                    if (!rd_in_range) begin
                        rd_data_next = '0;
                    end else if (wr_en && wr_in_range && (wr_idx == rd_idx)) begin
                        rd_data_next = merged;
                    end else begin
                        rd_data_next = mem[rd_idx];
                    end
                end
                addr_err_next = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_data_memory_ctl.sv
// tb/tb_data_memory_ctl.sv - self-checking bench for data_memory_ctl
module tb_data_memory_ctl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 20;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ready;
    logic              addr_err;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] last_rd;

    data_memory_ctl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ready    (ready),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        last_rd = 32'h0;
    endtask

    // Reference behaviour for one accepted cycle: write applied first, then read.
    task automatic model_step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [3:0] be, input logic re, input logic [31:0] ra,
                              output logic exp_valid, output logic exp_err);
        exp_err = 1'b0;
        if (we) begin
            if (wa < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_valid = re;
        if (re) begin
            if (ra < DEPTH) last_rd = model[ra];
            else begin
                last_rd = 32'h0;
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic v, e;
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        model_step(1'b1, a, d, be, 1'b0, 32'h0, v, e);
        cycle();
        idle();
    endtask

    task automatic check_read(input string name, input logic [31:0] a);
        logic v, e;
        idle();
        rd_en = 1'b1; rd_addr = a;
        model_step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, v, e);
        cycle();
        idle();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== last_rd || addr_err !== e) begin
            errors++;
            $display("FAIL %s addr=%0h: rd_valid=%b rd_data=%h addr_err=%b, required 1 %h %b",
                     name, a, rd_valid, rd_data, addr_err, last_rd, e);
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) cycle();
        vectors++;
        if (ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rd_valid=%b rd_data=%h addr_err=%b, required 0 0 0 0",
                     ready, rd_valid, rd_data, addr_err);
        end
        rst_n = 1'b1;
        model_clear();
        // Requests during the clear sequence must be ignored entirely.
        wr_en = 1'b1; wr_addr = 32'd0; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 32'hFFFF_FFFF;
        for (int e = 1; e <= DEPTH; e++) begin
            if (e % 2 == 0) wr_addr = 32'd25; else wr_addr = 32'(e % DEPTH);
            cycle();
            vectors++;
            if (ready !== (e == DEPTH) || rd_valid !== 1'b0 || addr_err !== 1'b0) begin
                errors++;
                $display("FAIL init_edge_%0d: ready=%b rd_valid=%b addr_err=%b, required %b 0 0",
                         e, ready, rd_valid, addr_err, (e == DEPTH));
            end
        end
        idle();
        for (int i = 0; i < DEPTH; i++) check_read("cleared", 32'(i));
    endtask

    task automatic test_full_word();
        do_write(32'd1, 32'hC8ECC8ED, 4'hF);
        check_read("full_word", 32'd1);
        cycle();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hC8ECC8ED) begin
            errors++;
            $display("FAIL valid_one_cycle: rd_valid=%b rd_data=%h, required 0 c8ecc8ed", rd_valid, rd_data);
        end
    endtask

    task automatic test_byte_enable();
        do_write(32'd3, 32'hFFFEFFFE, 4'hF);
        do_write(32'd3, 32'h12345678, 4'b0101);
        check_read("byte_enable", 32'd3);
        vectors++;
        if (rd_data !== 32'hFF34FF78) begin
            errors++;
            $display("FAIL byte_enable_const: rd_data=%h, required ff34ff78", rd_data);
        end
        do_write(32'd3, 32'h00000000, 4'b0000);
        check_read("be_zero", 32'd3);
    endtask

    task automatic test_collision();
        logic v, e;
        do_write(32'd2, 32'h11111111, 4'hF);
        wr_en = 1'b1; wr_addr = 32'd2; wr_data = 32'hC8ECC8EC; wr_be = 4'b0011;
        rd_en = 1'b1; rd_addr = 32'd2;
        model_step(1'b1, 32'd2, 32'hC8ECC8EC, 4'b0011, 1'b1, 32'd2, v, e);
        cycle();
        idle();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1111C8EC || last_rd !== 32'h1111C8EC) begin
            errors++;
            $display("FAIL collision: rd_valid=%b rd_data=%h, required 1 1111c8ec", rd_valid, rd_data);
        end
    endtask

    task automatic test_out_of_range();
        do_write(32'd20, 32'hDEADBEEF, 4'hF);
        vectors++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_pulse: addr_err=%b, required 1", addr_err);
        end
        cycle();
        vectors++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_drop: addr_err=%b, required 0", addr_err);
        end
        for (int i = 0; i < DEPTH; i++) check_read("oor_unchanged", 32'(i));
        check_read("rd_oor", 32'hFFFF_FFFF);
        vectors++;
        if (addr_err !== 1'b1 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL rd_oor_const: addr_err=%b rd_data=%h, required 1 0", addr_err, rd_data);
        end
    endtask

    task automatic test_random();
        logic v, e;
        logic [31:0] wa, ra, wd;
        logic [3:0] be;
        logic we, re;
        for (int n = 0; n < 400; n++) begin
            we = $urandom_range(0, 1) == 1;
            re = $urandom_range(0, 3) != 0;
            wa = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH + 3));
            ra = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH + 3));
            if ($urandom_range(0, 3) == 0) ra = wa;
            wd = $urandom();
            be = 4'($urandom_range(0, 15));
            wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
            rd_en = re; rd_addr = ra;
            model_step(we, wa, wd, be, re, ra, v, e);
            cycle();
            vectors++;
            if (rd_valid !== v || rd_data !== last_rd || addr_err !== e || ready !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d: rd_valid=%b rd_data=%h addr_err=%b ready=%b, required %b %h %b 1",
                         n, rd_valid, rd_data, addr_err, ready, v, last_rd, e);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_mid_reset();
        do_write(32'd5, 32'hA5A5A5A5, 4'hF);
        wr_en = 1'b1; wr_addr = 32'd20; wr_data = 32'h1; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 32'd5;
        cycle();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5A5A5 || addr_err !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: rd_valid=%b rd_data=%h addr_err=%b ready=%b, required 1 a5a5a5a5 1 1",
                     rd_valid, rd_data, addr_err, ready);
        end
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || ready !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: rd_valid=%b ready=%b addr_err=%b, required 0 0 0",
                     rd_valid, ready, addr_err);
        end
        cycle();
        rst_n = 1'b1;
        model_clear();
        for (int e = 1; e <= DEPTH; e++) begin
            cycle();
            vectors++;
            if (ready !== (e == DEPTH) || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL reinit_edge_%0d: ready=%b rd_valid=%b, required %b 0",
                         e, ready, rd_valid, (e == DEPTH));
            end
        end
        idle();
        check_read("after_reset", 32'd5);
        check_read("after_reset_1", 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_clear();
        test_reset();
        test_full_word();
        test_byte_enable();
        test_collision();
        test_out_of_range();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ctl.md
# data_memory_ctl

Parametrised single-clock data memory for the RISC datapath. It adds four things to the datapath memory: byte-enable writes, a registered read port with a valid strobe, out-of-range address detection, and a hardware clear sequence after reset. The block sits between the datapath's memory-write/address buses and the register-file write-back mux. Contents are zeroed by an internal state machine, not by simulation-only initialisation.

## Interface

- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 20, number of words; must be ≥ 2
- ADDR_W, 32, address bus width (full datapath address)
- Derived, not overridable: BE_W = DATA_W/8

Ports:

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request (datapath MW)
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- wr_be  in  BE_W  byte enables; bit i covers bits [8i+7:8i]
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read word address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: rd_data is updated this cycle
- ready  out  1  high when requests are accepted
- addr_err  out  1  one-cycle strobe: previous-cycle request was out of range

## Operation

- States: INIT (clear sequence), RUN.
- rst_n low (asynchronous):
  - state=INIT, clr_ptr=0, ready=0, rd_valid=0, rd_data=0, addr_err=0.
  - Memory array is not touched asynchronously.
- INIT:
  - Each rising edge with rst_n high writes zero to mem[clr_ptr] and increments clr_ptr.
  - On the edge that clears word DEPTH-1: state→RUN, ready←1.
  - wr_en and rd_en are ignored entirely: no write, rd_valid stays 0, addr_err stays 0.
- RUN, write:
  - wr_en=1 and wr_addr<DEPTH: each byte with its wr_be bit set is replaced by the matching wr_data byte. Other bytes are kept.
  - wr_be=0 means no change and no error.
  - wr_addr≥DEPTH: no array change; write error flagged.
- RUN, read:
  - rd_en=1 and rd_addr<DEPTH: next edge loads rd_data with mem[rd_addr] and sets rd_valid=1.
  - rd_addr≥DEPTH: rd_data←0, rd_valid←1, read error flagged.
  - rd_en=0: rd_valid←0 and rd_data holds its previous value.
- Collision, write-first: if a valid write and a valid read target the same address in the same cycle, rd_data returns the post-write word. That word is the merge of old bytes and wr_data bytes selected by wr_be.
- addr_err: registered OR of the write error and read error from the current cycle. It is high for exactly one cycle per erroring request cycle.
- Address comparison uses the full ADDR_W bits, with no truncation or wrap-around. Address DEPTH and all higher addresses are errors.
- Reset asserted at any time, mid-INIT or mid-RUN, restarts INIT from clr_ptr=0. All prior contents become zero after the new INIT completes.

## Timing

- Clear latency: ready rises after exactly DEPTH rising edges following rst_n deassertion. With the default of 20, ready is high after edge 20.
- The first request sampled is at edge DEPTH+1.
- Read latency: 1 cycle. A request sampled on edge N gives rd_data/rd_valid valid after edge N. One read can be accepted every cycle.
- Write latency: 1 cycle. A write on edge N is visible to a read sampled on edge N (collision rule) and on every later edge.
- addr_err is asserted after the same edge that would have completed the request.
- ready remains high in RUN until the next reset.
- No backpressure exists; ready is the only flow-control output.

## Test plan

- Reset/clear:
  - Pre-load X into the array, pulse rst_n low, then release.
  - ready must be 0 for edges 1–20 and 1 after edge 20.
  - Reading addresses 0–19 must return 0 with rd_valid 1 each cycle.
  - A wr_en pulse during INIT must have no effect.
- Full-word write/read:
  - Write 0xC8ECC8ED to addr 1 with wr_be=4'hF, then read addr 1.
  - Required: rd_data=0xC8ECC8ED with rd_valid high for exactly one cycle.
- Byte enables:
  - Write 0xFFFEFFFE to addr 3, then write 0x12345678 to addr 3 with wr_be=4'b0101.
  - Required: reading addr 3 returns 0xFF34FF78.
- Collision:
  - Set addr 2 to 0x11111111.
  - In the same cycle, write 0xC8ECC8EC with wr_be=4'b0011 and read addr 2.
  - Required: rd_data=0x1111C8EC.
- Out of range:
  - Write addr 20 with 0xDEADBEEF. Required: addr_err pulses 1 cycle and addresses 0–19 are unchanged.
  - Read addr 0xFFFFFFFF. Required: rd_valid=1, rd_data=0, addr_err=1.
- Mid-run reset:
  - Write 0xA5A5A5A5 to addr 5, then assert rst_n between edges while rd_en=1.
  - Required: rd_valid, ready and addr_err drop immediately.
  - Required: after the 20-edge clear, addr 5 reads 0.
